// File: rtl/pusch_pkg.sv
// Shared types and defaults for the PUSCH symbol buffering blocks.
package pusch_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  localparam int PP_DEPTH_DEF = 1200;
  localparam int PP_ADDR_W    = 11;

endpackage

// File: rtl/pp_bank_state.sv
// One ping-pong bank: lifecycle state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY
// plus the length of the block it holds.
module pp_bank_state
  import pusch_pkg::*;
#(
  parameter int LEN_W = PP_ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic             close,
  input  logic             start_drain,
  input  logic             done_drain,
  input  logic [LEN_W-1:0] len_in,
  output bank_state_t      state,
  output logic [LEN_W-1:0] len
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BANK_EMPTY;
      len   <= '0;
    end else begin
      case (state)
        BANK_EMPTY, BANK_FILLING: begin
          if (close) begin
            state <= BANK_FULL;
            len   <= len_in;
          end else if (fill) begin
            state <= BANK_FILLING;
          end
        end
        BANK_FULL:     if (start_drain) state <= BANK_DRAINING;
        BANK_DRAINING: if (done_drain)  state <= BANK_EMPTY;
        default:       state <= BANK_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong symbol buffer controller: mapper fills one bank while the consumer drains the other.
// Optional build macro PP_AUTO_CLOSE_EN: a write at wcnt = DEPTH-1 closes the bank automatically.
module pingpong_ctrl
  import pusch_pkg::*;
#(
  parameter int ADDR_WIDTH = PP_ADDR_W,
  parameter int DEPTH      = PP_DEPTH_DEF
) (
  input  logic                  CLK_PP,
  input  logic                  RST_PP,
  input  logic                  Wr_Valid_IN,
  input  logic                  Wr_Last_IN,
  output logic                  Wr_Ready_OUT,
  output logic [ADDR_WIDTH-1:0] Wr_Addr_OUT,
  output logic                  Wr_En_B0,
  output logic                  Wr_En_B1,
  input  logic                  Rd_Ready_IN,
  output logic [ADDR_WIDTH-1:0] Rd_Addr_OUT,
  output logic                  Rd_Bank_Sel,
  output logic                  Rd_En_OUT,
  output logic                  Rd_Valid_OUT,
  output logic                  Rd_Last_OUT,
  output logic                  Overflow_Flag,
  output logic [3:0]            dbg_bank_state
);

  localparam int CW = ADDR_WIDTH + 1;

  logic          wsel, rsel;
  logic [CW-1:0] wcnt, rcnt;
  bank_state_t   st0, st1, wstate, rstate;
  logic [CW-1:0] len0, len1, rlen;
  logic          at_cap, auto_close;
  logic          accept, close, drop;
  logic          rd_en, rd_last, start_drain;
  logic          rd_valid_q, rd_last_q, ovf_q;

  assign wstate = wsel ? st1 : st0;
  assign rstate = rsel ? st1 : st0;
  assign rlen   = rsel ? len1 : len0;

`ifdef PP_AUTO_CLOSE_EN
  assign at_cap     = 1'b0;
  assign auto_close = (wcnt == CW'(DEPTH - 1));
`else
  assign at_cap     = (wcnt == CW'(DEPTH));
  assign auto_close = 1'b0;
`endif

  // Handshakes: a write happens when Wr_Valid_IN & Wr_Ready_OUT (and the bank is not at
  // capacity); any other strobe is dropped. A read happens when the read bank is DRAINING
  // and Rd_Ready_IN is high; its data is valid one cycle later.
  assign Wr_Ready_OUT = ~RST_PP & ((wstate == BANK_EMPTY) | (wstate == BANK_FILLING));
  assign accept       = Wr_Valid_IN & Wr_Ready_OUT & ~at_cap;
  assign close        = accept & (Wr_Last_IN | auto_close);
  assign drop         = Wr_Valid_IN & ~accept;

  assign start_drain = (rstate == BANK_FULL);
  assign rd_en       = (rstate == BANK_DRAINING) & Rd_Ready_IN;
  assign rd_last     = rd_en & (rcnt == rlen - CW'(1));

  pp_bank_state #(.LEN_W(CW)) u_bank0 (
    .clk         (CLK_PP),
    .rst         (RST_PP),
    .fill        (accept & ~wsel),
    .close       (close & ~wsel),
    .start_drain (start_drain & ~rsel),
    .done_drain  (rd_last & ~rsel),
    .len_in      (wcnt + CW'(1)),
    .state       (st0),
    .len         (len0)
  );

  pp_bank_state #(.LEN_W(CW)) u_bank1 (
    .clk         (CLK_PP),
    .rst         (RST_PP),
    .fill        (accept & wsel),
    .close       (close & wsel),
    .start_drain (start_drain & rsel),
    .done_drain  (rd_last & rsel),
    .len_in      (wcnt + CW'(1)),
    .state       (st1),
    .len         (len1)
  );

  always_ff @(posedge CLK_PP or posedge RST_PP) begin
    if (RST_PP) begin
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (close) begin
        wcnt <= '0;
        wsel <= ~wsel;
      end else if (accept) begin
        wcnt <= wcnt + CW'(1);
      end
      if (rd_last) begin
        rcnt <= '0;
        rsel <= ~rsel;
      end else if (rd_en) begin
        rcnt <= rcnt + CW'(1);
      end else if (start_drain) begin
        rcnt <= '0;
      end
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_last;
      ovf_q      <= ovf_q | drop;
    end
  end

  assign Wr_Addr_OUT    = wcnt[ADDR_WIDTH-1:0];
  assign Wr_En_B0       = accept & ~wsel;
  assign Wr_En_B1       = accept & wsel;
  assign Rd_Addr_OUT    = rcnt[ADDR_WIDTH-1:0];
  assign Rd_Bank_Sel    = rsel;
  assign Rd_En_OUT      = rd_en;
  assign Rd_Valid_OUT   = rd_valid_q;
  assign Rd_Last_OUT    = rd_last_q;
  assign Overflow_Flag  = ovf_q;
  assign dbg_bank_state = {st1, st0};

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl: a cycle-by-cycle vector table plus multi-cycle block sequences.
module tb_pingpong_ctrl;

  logic        clk, rst;
  logic        wr_valid, wr_last, rd_ready;
  logic        wr_ready, wr_en_b0, wr_en_b1;
  logic [10:0] wr_addr, rd_addr;
  logic        rd_bank_sel, rd_en, rd_valid, rd_last, overflow;
  logic [3:0]  dbg_bank_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];

  typedef struct packed {
    logic        wrdy, we0, we1;
    logic [10:0] waddr;
    logic        ren;
    logic [10:0] raddr;
    logic        rsel, rval, rlast, ovf;
  } out_t;

  typedef struct {
    logic wv, wl, rr;
    out_t exp;
  } vec_t;

  vec_t tbl[11];

  pingpong_ctrl dut (
    .CLK_PP         (clk),
    .RST_PP         (rst),
    .Wr_Valid_IN    (wr_valid),
    .Wr_Last_IN     (wr_last),
    .Wr_Ready_OUT   (wr_ready),
    .Wr_Addr_OUT    (wr_addr),
    .Wr_En_B0       (wr_en_b0),
    .Wr_En_B1       (wr_en_b1),
    .Rd_Ready_IN    (rd_ready),
    .Rd_Addr_OUT    (rd_addr),
    .Rd_Bank_Sel    (rd_bank_sel),
    .Rd_En_OUT      (rd_en),
    .Rd_Valid_OUT   (rd_valid),
    .Rd_Last_OUT    (rd_last),
    .Overflow_Flag  (overflow),
    .dbg_bank_state (dbg_bank_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic out_t obs();
    out_t o;
    o = {wr_ready, wr_en_b0, wr_en_b1, wr_addr, rd_en, rd_addr,
         rd_bank_sel, rd_valid, rd_last, overflow};
    return o;
  endfunction

  function automatic vec_t mk(bit wv, bit wl, bit rr, bit wrdy, bit we0, bit we1, int wa,
                              bit ren, int ra, bit rs, bit rv, bit rl, bit ov);
    vec_t v;
    v.wv = wv; v.wl = wl; v.rr = rr;
    v.exp = {wrdy, we0, we1, wa[10:0], ren, ra[10:0], rs, rv, rl, ov};
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'(obs()), 64'd0);
    chk("reset_banks", 64'(dbg_bank_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Writes n symbols; respect=1 waits for Wr_Ready_OUT, expect_drop=1 expects every strobe dropped.
  task automatic write_block(int n, bit bank, bit respect, bit expect_drop, bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      if (respect) begin
        t = 0;
        while (!wr_ready && t < 4000) begin
          @(negedge clk);
          #1;
          t++;
        end
        chk("wr_ready_wait", 64'(wr_ready), 64'd1);
      end
      wr_valid = 1'b1;
      wr_last  = with_last && (i == n - 1);
      #1;
      if (expect_drop)
        chk("wr_drop", 64'({wr_ready, wr_en_b0, wr_en_b1}), 64'd0);
      else
        chk("wr_en_addr", 64'({wr_en_b0, wr_en_b1, wr_addr}),
            64'({bank == 1'b0, bank == 1'b1, i[10:0]}));
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Scoreboard for one drained block; first_rd is the iteration index of the first read.
  task automatic drain_block(bit bank, int len, bit toggle, output int first_rd);
    int nval, k;
    logic [10:0] e;
    exp_q.delete();
    for (int j = 0; j < len; j++) exp_q.push_back(j[10:0]);
    nval = 0; k = 0; first_rd = -1;
    while (nval < len && k < 5000) begin
      rd_ready = toggle ? (k % 2 == 0) : 1'b1;
      #1;
      if (rd_en) begin
        if (first_rd < 0) first_rd = k;
        if (exp_q.size() == 0) begin
          chk("rd_extra_read", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_bank_addr", 64'({rd_bank_sel, rd_addr}), 64'({bank, e}));
        end
      end
      if (rd_valid) begin
        nval++;
        chk("rd_last_flag", 64'(rd_last), 64'(nval == len));
      end
      @(negedge clk);
      k++;
    end
    chk("rd_valid_count", 64'(nval), 64'(len));
    chk("rd_all_addrs", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int first, t;
    rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;

    //             wv wl rr | wrdy we0 we1 waddr | ren raddr rsel | rval rlast ovf
    tbl[0]  = mk(1, 0, 1,   1, 1, 0, 0,   0, 0, 0,   0, 0, 0);
    tbl[1]  = mk(1, 0, 1,   1, 1, 0, 1,   0, 0, 0,   0, 0, 0);
    tbl[2]  = mk(1, 1, 1,   1, 1, 0, 2,   0, 0, 0,   0, 0, 0);
    tbl[3]  = mk(0, 0, 1,   1, 0, 0, 0,   0, 0, 0,   0, 0, 0);
    tbl[4]  = mk(1, 1, 1,   1, 0, 1, 0,   1, 0, 0,   0, 0, 0);
    tbl[5]  = mk(1, 0, 1,   0, 0, 0, 0,   1, 1, 0,   1, 0, 0);
    tbl[6]  = mk(0, 0, 1,   0, 0, 0, 0,   1, 2, 0,   1, 0, 1);
    tbl[7]  = mk(0, 0, 1,   1, 0, 0, 0,   0, 0, 1,   1, 1, 1);
    tbl[8]  = mk(0, 0, 1,   1, 0, 0, 0,   1, 0, 1,   0, 0, 1);
    tbl[9]  = mk(0, 0, 1,   1, 0, 0, 0,   0, 0, 0,   1, 1, 1);
    tbl[10] = mk(0, 0, 0,   1, 0, 0, 0,   0, 0, 0,   0, 0, 1);

    // Vector table: 3-symbol block in B0, 1-symbol block in B1, one dropped strobe.
    do_reset();
    for (int r = 0; r < 11; r++) begin
      wr_valid = tbl[r].wv; wr_last = tbl[r].wl; rd_ready = tbl[r].rr;
      #1;
      chk($sformatf("vec%0d", r), 64'(obs()), 64'(tbl[r].exp));
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;

    // Full 1200-symbol block, first read two cycles after the close.
    do_reset();
    write_block(1200, 1'b0, 1'b1, 1'b0, 1'b1);
    drain_block(1'b0, 1200, 1'b0, first);
    chk("t1_close_to_read", 64'(first), 64'd1);
    rd_ready = 1'b0;

    // Three 300-symbol blocks with no consumer: third block is refused.
    do_reset();
    write_block(300, 1'b0, 1'b1, 1'b0, 1'b1);
    write_block(300, 1'b1, 1'b1, 1'b0, 1'b1);
    write_block(300, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_banks", 64'(dbg_bank_state), 64'b1011);

    // Same traffic with the consumer always ready: banks alternate, no overflow.
    do_reset();
    rd_ready = 1'b1;
    fork
      begin
        write_block(300, 1'b0, 1'b1, 1'b0, 1'b1);
        write_block(300, 1'b1, 1'b1, 1'b0, 1'b1);
        write_block(300, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      begin
        int f0, f1, f2;
        drain_block(1'b0, 300, 1'b0, f0);
        drain_block(1'b1, 300, 1'b0, f1);
        drain_block(1'b0, 300, 1'b0, f2);
      end
    join
    #1;
    chk("t3_no_overflow", 64'(overflow), 64'd0);
    rd_ready = 1'b0;

    // 1201 strobes without a last marker.
    do_reset();
    for (int i = 0; i < 1201; i++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_last = 1'b0;
      #1;
`ifdef PP_AUTO_CLOSE_EN
      if (i < 1200)
        chk("t4_wr_b0", 64'({wr_en_b0, wr_en_b1, wr_addr}), 64'({1'b1, 1'b0, i[10:0]}));
      else
        chk("t4_wr_b1_addr0", 64'({wr_en_b0, wr_en_b1, wr_addr}), 64'({1'b0, 1'b1, 11'd0}));
`else
      if (i < 1200)
        chk("t4_wr_b0", 64'({wr_en_b0, wr_en_b1, wr_addr}), 64'({1'b1, 1'b0, i[10:0]}));
      else
        chk("t4_drop_at_depth", 64'({wr_en_b0, wr_en_b1}), 64'd0);
`endif
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
`ifdef PP_AUTO_CLOSE_EN
    chk("t4_overflow", 64'(overflow), 64'd0);
    chk("t4_banks", 64'(dbg_bank_state), 64'b0111);
`else
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_banks", 64'(dbg_bank_state), 64'b0001);
`endif

    // 10-symbol block drained with Rd_Ready_IN toggling.
    do_reset();
    write_block(10, 1'b0, 1'b1, 1'b0, 1'b1);
    drain_block(1'b0, 10, 1'b1, first);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_no_extra_valid", 64'({rd_en, rd_valid}), 64'd0);
      @(negedge clk);
    end
    rd_ready = 1'b0;

    // Reset in the middle of a drain, then a fresh 4-symbol block.
    do_reset();
    write_block(10, 1'b0, 1'b1, 1'b0, 1'b1);
    rd_ready = 1'b1;
    t = 0;
    #1;
    while (!(rd_en && rd_addr == 11'd5) && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("t6_reach_rcnt5", 64'({rd_en, rd_addr}), 64'({1'b1, 11'd5}));
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs", 64'(obs()), 64'd0);
    chk("t6_rst_banks", 64'(dbg_bank_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_ready = 1'b0;
    write_block(4, 1'b0, 1'b1, 1'b0, 1'b1);
    drain_block(1'b0, 4, 1'b0, first);
    chk("t6_new_block_latency", 64'(first), 64'd1);
    rd_ready = 1'b0;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
